fifo_uart_tx: RTL and testbench

//  Serial transmitter that drains the byte fifo. It pulls one word per frame through
//  the fifo read port (data_available / read_data / read_strobe) and shifts it out
//  LSB-first as 8N1-style async serial.

---
 rtl/fifo_uart_tx_pkg.sv | 18 +
 rtl/fifo_uart_tx_if.sv | 25 ++
 rtl/fifo_uart_tx_bit_timer.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the fifo-draining UART transmitter.
//   tx_state_t  : frame FSM state encoding (IDLE/START/DATA/STOP). The RX side
//                 reuses the same encoding.
//   clog2_min1  : ceil(log2(v)) clamped to at least 1, for counter widths.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Fifo read port between the byte fifo (master) and the transmitter (slave).
//   data_available : fifo not empty (acts as "valid")
//   read_data      : fifo head word, valid while data_available is high
//   read_strobe    : one-cycle pop; the head is consumed on the rising clock edge
//                    that ends a cycle with data_available && read_strobe both high.
//                    read_strobe is never asserted while data_available is low.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             data_available;
    logic [WIDTH-1:0] read_data;
    logic             read_strobe;

    modport master (
        output data_available,
        output read_data,
        input  read_strobe
    );

    modport slave (
        input  data_available,
        input  read_data,
        output read_strobe
    );
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer: loadable down-counter that marks the end of each serial bit.
//   clk, reset : system clock, synchronous active-high reset (count clears)
//   load       : restart the bit period (count <= DIVISOR-1)
//   tick       : high in the last cycle of a bit period (count == 0)
// At zero the counter reloads by itself, so consecutive bits stay DIVISOR
// cycles apart and the phase is set by the most recent load.
module uart_bit_timer
    import fifo_uart_tx_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);
    localparam int            TW     = clog2_min1(DIVISOR);
    localparam logic [TW-1:0] RELOAD = TW'(DIVISOR - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte fifo and sends each word LSB-first as 8N1-style
// async serial (start bit, WIDTH data bits, STOP_BITS stop bits).
//   clk, reset : system clock, synchronous active-high reset
//   rd         : fifo read port (slave side: data_available, read_data, read_strobe)
//   serial     : TX line, registered, idles high
//   busy       : registered, high from first START cycle through last STOP cycle
//   state_o    : current frame state, for debug/observation
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DIVISOR   = 16,
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    fifo_uart_tx_if.slave       rd,
    output logic                serial,
    output logic                busy,
    output tx_state_t           state_o
);
    localparam int            CW        = clog2_min1(WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             frame_end;
    logic             load;

    // Last cycle of the final stop bit: the only point besides IDLE where a new
    // word may be pulled, which gives gap-free back-to-back frames.
    assign frame_end = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
    assign load      = !reset && rd.data_available && ((state_q == ST_IDLE) || frame_end);

    assign rd.read_strobe = load;
    assign serial         = serial_q;
    assign busy           = busy_q;
    assign state_o        = state_q;

    uart_bit_timer #(
        .DIVISOR (DIVISOR)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (load) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA:  if (tick && bit_cnt_q == LAST_DATA) state_d = ST_STOP;
            ST_STOP:  if (frame_end) state_d = load ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values. serial and busy are computed one cycle
    // ahead so the registered line changes on the same edge as the state.
    always_comb begin
        serial_d  = serial_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (load) begin
                    shift_d   = rd.read_data;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    serial_d  = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        // WIDTH bits sent; the counter is reused for stop bits.
                        serial_d  = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        serial_d  = shift_d[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                serial_d = 1'b1;
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        if (load) begin
                            shift_d   = rd.read_data;
                            serial_d  = 1'b0;
                            busy_d    = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            busy_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (STOP_BITS=1 and STOP_BITS=2, DIVISOR=4,
// WIDTH=8), each fed by a queue-based fifo model. Every cycle the outputs are
// logged at the falling edge; the scenario tasks compare the logs with
// hand-derived frame shapes.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(8)) bus1 ();
    fifo_uart_tx_if #(.WIDTH(8)) bus2 ();

    logic      serial1, busy1, serial2, busy2;
    tx_state_t state1, state2;

    fifo_uart_tx #(.DIVISOR(DIV), .WIDTH(8), .STOP_BITS(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .rd      (bus1),
        .serial  (serial1),
        .busy    (busy1),
        .state_o (state1)
    );

    fifo_uart_tx #(.DIVISOR(DIV), .WIDTH(8), .STOP_BITS(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .rd      (bus2),
        .serial  (serial2),
        .busy    (busy2),
        .state_o (state2)
    );

    logic [7:0] fq1[$];
    logic [7:0] fq2[$];
    logic       s1_log[$], b1_log[$], r1_log[$];
    logic       s2_log[$], b2_log[$], r2_log[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // ---------------- fifo model / cycle driver ----------------
    task automatic drive_fifo();
        bus1.data_available = (fq1.size() != 0);
        bus1.read_data      = (fq1.size() != 0) ? fq1[0] : 8'h00;
        bus2.data_available = (fq2.size() != 0);
        bus2.read_data      = (fq2.size() != 0) ? fq2[0] : 8'h00;
    endtask

    // Called at a falling edge: log outputs, cross one rising edge, pop on strobe.
    task automatic cycle();
        logic st1, st2;
        #1;
        st1 = bus1.read_strobe;
        st2 = bus2.read_strobe;
        s1_log.push_back(serial1); b1_log.push_back(busy1); r1_log.push_back(st1);
        s2_log.push_back(serial2); b2_log.push_back(busy2); r2_log.push_back(st2);
        @(posedge clk);
        #1;
        if (st1 === 1'b1 && fq1.size() != 0) void'(fq1.pop_front());
        if (st2 === 1'b1 && fq2.size() != 0) void'(fq2.pop_front());
        drive_fifo();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        s1_log.delete(); b1_log.delete(); r1_log.delete();
        s2_log.delete(); b2_log.delete(); r2_log.delete();
    endtask

    // Expected line level in 1-based cycle k of a frame (k=1 is first start cycle).
    function automatic logic exp_serial(input logic [7:0] b, input int k);
        if (k <= DIV) return 1'b0;
        if (k <= 9 * DIV) return b[(k - DIV - 1) / DIV];
        return 1'b1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad_s, bad_b, bad_r;
        clear_logs();
        reset = 1'b1;
        drive_fifo();
        @(posedge clk);
        @(negedge clk);
        repeat (5) cycle();
        n_cmp++;
        if (state1 !== ST_IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d expected %0d", state1, ST_IDLE);
        end
        reset = 1'b0;
        repeat (50) cycle();
        bad_s = 0; bad_b = 0; bad_r = 0;
        foreach (s1_log[k]) begin
            if (s1_log[k] !== 1'b1 || s2_log[k] !== 1'b1) bad_s++;
            if (b1_log[k] !== 1'b0 || b2_log[k] !== 1'b0) bad_b++;
            if (r1_log[k] !== 1'b0 || r2_log[k] !== 1'b0) bad_r++;
        end
        n_cmp++;
        if (bad_s !== 0) begin n_bad++; $display("FAIL reset_serial: got %0d non-idle cycles expected 0", bad_s); end
        n_cmp++;
        if (bad_b !== 0) begin n_bad++; $display("FAIL reset_busy: got %0d busy cycles expected 0", bad_b); end
        n_cmp++;
        if (bad_r !== 0) begin n_bad++; $display("FAIL reset_strobe: got %0d strobe cycles expected 0", bad_r); end
    endtask

    task automatic test_single_frame();
        int strobes, busies;
        logic e;
        clear_logs();
        fq1.push_back(8'h55);
        drive_fifo();
        repeat (60) cycle();
        strobes = 0; busies = 0;
        foreach (r1_log[k]) begin
            if (r1_log[k] === 1'b1) strobes++;
            if (b1_log[k] === 1'b1) busies++;
        end
        n_cmp++;
        if (r1_log[0] !== 1'b1) begin n_bad++; $display("FAIL single_strobe_pos: got %b expected 1", r1_log[0]); end
        n_cmp++;
        if (strobes !== 1) begin n_bad++; $display("FAIL single_strobe_cnt: got %0d expected 1", strobes); end
        n_cmp++;
        if (busies !== 40) begin n_bad++; $display("FAIL single_busy_cnt: got %0d expected 40", busies); end
        n_cmp++;
        if (b1_log[1] !== 1'b1 || b1_log[40] !== 1'b1 || b1_log[41] !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_edges: got %b%b%b expected 110", b1_log[1], b1_log[40], b1_log[41]);
        end
        for (int k = 0; k <= 44; k++) begin
            e = (k >= 1 && k <= 40) ? exp_serial(8'h55, k) : 1'b1;
            n_cmp++;
            if (s1_log[k] !== e) begin
                n_bad++; $display("FAIL single_serial[%0d]: got %b expected %b", k, s1_log[k], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes_in[2];
        logic [7:0] dec;
        int strobes, busies, f, kk;
        logic e;
        bytes_in[0] = 8'hA5;
        bytes_in[1] = 8'h3C;
        clear_logs();
        fq1.push_back(8'hA5);
        fq1.push_back(8'h3C);
        drive_fifo();
        repeat (100) cycle();
        strobes = 0; busies = 0;
        foreach (r1_log[k]) begin
            if (r1_log[k] === 1'b1) strobes++;
            if (b1_log[k] === 1'b1) busies++;
        end
        n_cmp++;
        if (r1_log[0] !== 1'b1 || r1_log[40] !== 1'b1) begin
            n_bad++; $display("FAIL b2b_strobe_pos: got %b/%b expected 1/1", r1_log[0], r1_log[40]);
        end
        n_cmp++;
        if (strobes !== 2) begin n_bad++; $display("FAIL b2b_strobe_cnt: got %0d expected 2", strobes); end
        n_cmp++;
        if (busies !== 80 || b1_log[81] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy: got %0d cycles end=%b expected 80 end=0", busies, b1_log[81]);
        end
        for (int k = 1; k <= 80; k++) begin
            f  = (k - 1) / 40;
            kk = k - 40 * f;
            e  = exp_serial(bytes_in[f], kk);
            n_cmp++;
            if (s1_log[k] !== e) begin
                n_bad++; $display("FAIL b2b_serial[%0d]: got %b expected %b", k, s1_log[k], e);
            end
        end
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 8; i++) dec[i] = s1_log[1 + 40 * fr + DIV + i * DIV + DIV / 2];
            n_cmp++;
            if (dec !== bytes_in[fr]) begin
                n_bad++; $display("FAIL b2b_decode%0d: got %h expected %h", fr, dec, bytes_in[fr]);
            end
        end
        n_cmp++;
        if (bus1.data_available !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drained: got %b expected 0", bus1.data_available);
        end
    endtask

    task automatic test_reset_mid_frame();
        int strobes, bad;
        clear_logs();
        fq1.push_back(8'hFF);
        drive_fifo();
        repeat (18) cycle();
        reset = 1'b1;       // cycle 18 lies inside data bit 3 (cycles 17..20)
        cycle();
        reset = 1'b0;
        repeat (30) cycle();
        n_cmp++;
        if (s1_log[1] !== 1'b0 || b1_log[18] !== 1'b1) begin
            n_bad++; $display("FAIL midrst_pre: got serial=%b busy=%b expected 0/1", s1_log[1], b1_log[18]);
        end
        n_cmp++;
        if (s1_log[19] !== 1'b1 || b1_log[19] !== 1'b0) begin
            n_bad++; $display("FAIL midrst_next: got serial=%b busy=%b expected 1/0", s1_log[19], b1_log[19]);
        end
        strobes = 0; bad = 0;
        foreach (r1_log[k]) if (r1_log[k] === 1'b1) strobes++;
        for (int k = 19; k < s1_log.size(); k++) begin
            if (s1_log[k] !== 1'b1 || b1_log[k] !== 1'b0) bad++;
        end
        n_cmp++;
        if (strobes !== 1) begin n_bad++; $display("FAIL midrst_strobes: got %0d expected 1", strobes); end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL midrst_after: got %0d active cycles expected 0", bad); end
        n_cmp++;
        if (state1 !== ST_IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d expected %0d", state1, ST_IDLE); end
    endtask

    task automatic test_idle_hold();
        int strobes, lows;
        clear_logs();
        drive_fifo();
        repeat (200) cycle();
        strobes = 0; lows = 0;
        foreach (r1_log[k]) begin
            if (r1_log[k] !== 1'b0) strobes++;
            if (s1_log[k] !== 1'b1) lows++;
        end
        n_cmp++;
        if (strobes !== 0) begin n_bad++; $display("FAIL idle_strobe: got %0d expected 0", strobes); end
        n_cmp++;
        if (lows !== 0) begin n_bad++; $display("FAIL idle_serial: got %0d non-high cycles expected 0", lows); end
    endtask

    task automatic test_two_stop_bits();
        logic [7:0] bytes_in[2];
        logic [7:0] dec;
        int strobes, busies, f, kk;
        logic e;
        bytes_in[0] = 8'h00;
        bytes_in[1] = 8'h01;
        clear_logs();
        fq2.push_back(8'h00);
        fq2.push_back(8'h01);
        drive_fifo();
        repeat (110) cycle();
        strobes = 0; busies = 0;
        foreach (r2_log[k]) begin
            if (r2_log[k] === 1'b1) strobes++;
            if (b2_log[k] === 1'b1) busies++;
        end
        n_cmp++;
        if (r2_log[0] !== 1'b1 || r2_log[44] !== 1'b1) begin
            n_bad++; $display("FAIL stop2_strobe_pos: got %b/%b expected 1/1", r2_log[0], r2_log[44]);
        end
        n_cmp++;
        if (strobes !== 2) begin n_bad++; $display("FAIL stop2_strobe_cnt: got %0d expected 2", strobes); end
        n_cmp++;
        if (busies !== 88 || b2_log[89] !== 1'b0) begin
            n_bad++; $display("FAIL stop2_busy: got %0d cycles end=%b expected 88 end=0", busies, b2_log[89]);
        end
        for (int k = 1; k <= 92; k++) begin
            f  = (k - 1) / 44;
            kk = k - 44 * f;
            e  = (f < 2) ? exp_serial(bytes_in[f], kk) : 1'b1;
            n_cmp++;
            if (s2_log[k] !== e) begin
                n_bad++; $display("FAIL stop2_serial[%0d]: got %b expected %b", k, s2_log[k], e);
            end
        end
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 8; i++) dec[i] = s2_log[1 + 44 * fr + DIV + i * DIV + DIV / 2];
            n_cmp++;
            if (dec !== bytes_in[fr]) begin
                n_bad++; $display("FAIL stop2_decode%0d: got %h expected %h", fr, dec, bytes_in[fr]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_hold();
        test_two_stop_bits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
